rx_pcs_decode: RTL and testbench
================================

RX_PCS_DECODE -- requirements
Module: rx_pcs_decode

Interface
REQ-001 SHALL have port GTX_CLK, input, 1 bit: sole clock; all state changes on rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port rx_code_group, input, 10 bits: received 8B/10B code-group; bit 9 = a … bit 0 = j (abcdei fghj).
REQ-004 SHALL have port sync_status, input, 1 bit: 1 = code-group alignment acquired (from sync block).
REQ-005 SHALL have port RXD, output, 8 bits: GMII receive data.
REQ-006 SHALL have port RX_DV, output, 1 bit: GMII receive data valid.
REQ-007 SHALL have port RX_ER, output, 1 bit: GMII receive error.

Function
REQ-010 SHALL decode rx_code_group with 5b/6b and 3b/4b sub-decoders into {K flag, 8-bit value HGFEDCBA}, plus a valid flag (code-group legal in the current running disparity).
REQ-011 SHALL recognise special groups K28.5 (comma), K27.7 /S/, K29.7 /T/, K23.7 /R/, K30.7 /V/; any other K code SHALL be treated as invalid.
REQ-012 SHALL track running disparity (RD): RD- after reset; updated every clock from the sub-block disparities of the sampled group, including invalid groups (RD follows the received bits).
REQ-013 SHALL register all outputs; outputs reflect the code-group sampled on the same rising edge (1-cycle latency from input to visible output).
REQ-014 SHALL implement FSM states LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, TRI_RRI.
REQ-015 sync_status=0 in any state SHALL force LINK_FAILED next cycle; in LINK_FAILED RX_DV=0, RX_ER=0, RXD=0x00.
REQ-016 LINK_FAILED -> WAIT_FOR_K when sync_status=1.
REQ-017 WAIT_FOR_K: K28.5 -> RX_K; anything else stays; RX_DV=0, RX_ER=0.
REQ-018 RX_K: valid D group -> IDLE_D; any K or invalid group -> WAIT_FOR_K; RX_DV=0, RX_ER=0.
REQ-019 IDLE_D: K28.5 -> RX_K; /S/ -> RECEIVE with RX_DV=1, RX_ER=0, RXD=0x55 for that cycle; other -> WAIT_FOR_K, RX_DV=0.
REQ-020 RECEIVE, valid D group: RXD=decoded byte, RX_DV=1, RX_ER=0.
REQ-021 RECEIVE, /T/: RX_DV=0, RX_ER=0, RXD=0x00, -> TRI_RRI.
REQ-022 RECEIVE, K28.5 (early end): RX_DV=0, RX_ER=1, RXD=0x00, -> RX_K.
REQ-023 RECEIVE, /V/, invalid group, RD error, or any other K: RX_DV=1, RX_ER=1, RXD=0x00, remain in RECEIVE.
REQ-024 TRI_RRI: /R/ -> WAIT_FOR_K with RX_DV=0, RX_ER=0; further /R/ or K28.5 accepted via WAIT_FOR_K path; non-/R/ -> WAIT_FOR_K with RX_ER=1 for one cycle.
REQ-025 /S/ received while in RECEIVE SHALL be treated as error per REQ-023 (no nested packet).
REQ-026 RXD SHALL be 0x00 whenever RX_DV=0.

Reset
REQ-030 RESET=0 SHALL asynchronously force state=LINK_FAILED, RD=RD-, RXD=0x00, RX_DV=0, RX_ER=0.
REQ-031 RESET deassertion SHALL take effect on the next GTX_CLK rising edge; reset mid-packet SHALL drop RX_DV immediately with no RX_ER pulse.

Verification
REQ-040 Reset, sync_status=1, stream K28.5 RD- (0x0FA), D16.2 RD+ (0x245) repeated -> state cycles RX_K/IDLE_D, RX_DV=0, RX_ER=0, RD ends RD- after each /I2/.
REQ-041 From idle: /S/ (0x368), D21.5 (0x2AA) x3, /T/ (0x2E8), /R/ (0x3A8), then /I2/ -> RXD 0x55,0xB5,0xB5,0xB5 with RX_DV=1 for 4 cycles, then RX_DV=0, RX_ER=0 throughout.
REQ-042 Mid-packet inject /V/ or an illegal 10-bit value (0x000) -> exactly one cycle RX_DV=1, RX_ER=1, RXD=0x00; following D21.5 decodes normally to 0xB5.
REQ-043 Mid-packet K28.5 -> one cycle RX_DV=0, RX_ER=1; next D16.2 returns to idle with RX_ER=0.
REQ-044 Mid-packet sync_status=0 -> next cycle RX_DV=0, RX_ER=0, RXD=0x00; no reception until WAIT_FOR_K/RX_K/IDLE_D sequence completes.
REQ-045 RESET=0 asserted between clock edges during RECEIVE -> outputs 0 immediately, before next edge; after release, packet data ignored until K28.5+D sequence.

Source files
------------

// File: rtl/rx_pcs_decode.sv
// 1000BASE-X receive PCS: 8B/10B code-group decode, running disparity
// tracking and the GMII receive state machine. All outputs are registered
// and reflect the code-group sampled on the same rising edge.
module rx_pcs_decode (
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic [9:0] rx_code_group,
    input  logic       sync_status,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER
);

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        RECEIVE,
        TRI_RRI
    } state_t;

    state_t     state, state_nxt;
    logic       rd;              // 0 = RD-, 1 = RD+
    logic       rd_mid, rd_nxt;  // RD after the 6b block / after the whole group
    logic [7:0] rxd_nxt;
    logic       dv_nxt, er_nxt;

    logic [6:0] d6;              // {legal in RD-, legal in RD+, EDCBA}
    logic [3:0] d4;              // {legal, HGF}
    logic       ok6, d_valid;
    logic [7:0] d_byte;
    logic       is_comma, is_start, is_term, is_carrier;

    // 5b/6b data decode (abcdei); K28 6b groups are not data and fall to default
    function automatic logic [6:0] dec6(input logic [5:0] s);
        case (s)
            6'b100111: dec6 = {2'b10, 5'd0};
            6'b011000: dec6 = {2'b01, 5'd0};
            6'b011101: dec6 = {2'b10, 5'd1};
            6'b100010: dec6 = {2'b01, 5'd1};
            6'b101101: dec6 = {2'b10, 5'd2};
            6'b010010: dec6 = {2'b01, 5'd2};
            6'b110001: dec6 = {2'b11, 5'd3};
            6'b110101: dec6 = {2'b10, 5'd4};
            6'b001010: dec6 = {2'b01, 5'd4};
            6'b101001: dec6 = {2'b11, 5'd5};
            6'b011001: dec6 = {2'b11, 5'd6};
            6'b111000: dec6 = {2'b10, 5'd7};
            6'b000111: dec6 = {2'b01, 5'd7};
            6'b111001: dec6 = {2'b10, 5'd8};
            6'b000110: dec6 = {2'b01, 5'd8};
            6'b100101: dec6 = {2'b11, 5'd9};
            6'b010101: dec6 = {2'b11, 5'd10};
            6'b110100: dec6 = {2'b11, 5'd11};
            6'b001101: dec6 = {2'b11, 5'd12};
            6'b101100: dec6 = {2'b11, 5'd13};
            6'b011100: dec6 = {2'b11, 5'd14};
            6'b010111: dec6 = {2'b10, 5'd15};
            6'b101000: dec6 = {2'b01, 5'd15};
            6'b011011: dec6 = {2'b10, 5'd16};
            6'b100100: dec6 = {2'b01, 5'd16};
            6'b100011: dec6 = {2'b11, 5'd17};
            6'b010011: dec6 = {2'b11, 5'd18};
            6'b110010: dec6 = {2'b11, 5'd19};
            6'b001011: dec6 = {2'b11, 5'd20};
            6'b101010: dec6 = {2'b11, 5'd21};
            6'b011010: dec6 = {2'b11, 5'd22};
            6'b111010: dec6 = {2'b10, 5'd23};
            6'b000101: dec6 = {2'b01, 5'd23};
            6'b110011: dec6 = {2'b10, 5'd24};
            6'b001100: dec6 = {2'b01, 5'd24};
            6'b100110: dec6 = {2'b11, 5'd25};
            6'b010110: dec6 = {2'b11, 5'd26};
            6'b110110: dec6 = {2'b10, 5'd27};
            6'b001001: dec6 = {2'b01, 5'd27};
            6'b001110: dec6 = {2'b11, 5'd28};
            6'b101110: dec6 = {2'b10, 5'd29};
            6'b010001: dec6 = {2'b01, 5'd29};
            6'b011110: dec6 = {2'b10, 5'd30};
            6'b100001: dec6 = {2'b01, 5'd30};
            6'b101011: dec6 = {2'b10, 5'd31};
            6'b010100: dec6 = {2'b01, 5'd31};
            default:   dec6 = '0;
        endcase
    endfunction

    // 3b/4b data decode (fghj); the A7 alternate is only legal after 5b
    // values 17/18/20 in RD- or 11/13/14 in RD+, which also keeps the
    // Kxx.7 specials from aliasing onto D.x.7
    function automatic logic [3:0] dec4(input logic [3:0] f, input logic rdm,
                                        input logic [4:0] x);
        logic a7m, a7p;
        a7m = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        a7p = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        case (f)
            4'b1011: dec4 = {!rdm, 3'd0};
            4'b0100: dec4 = {rdm, 3'd0};
            4'b1001: dec4 = {1'b1, 3'd1};
            4'b0101: dec4 = {1'b1, 3'd2};
            4'b1100: dec4 = {!rdm, 3'd3};
            4'b0011: dec4 = {rdm, 3'd3};
            4'b1101: dec4 = {!rdm, 3'd4};
            4'b0010: dec4 = {rdm, 3'd4};
            4'b1010: dec4 = {1'b1, 3'd5};
            4'b0110: dec4 = {1'b1, 3'd6};
            4'b1110: dec4 = {!rdm && !a7m, 3'd7};
            4'b0001: dec4 = {rdm && !a7p, 3'd7};
            4'b0111: dec4 = {!rdm && a7m, 3'd7};
            4'b1000: dec4 = {rdm && a7p, 3'd7};
            default: dec4 = '0;
        endcase
    endfunction

    // Code-group decode, special-group match and disparity of the sampled bits
    always_comb begin
        d6      = dec6(rx_code_group[9:4]);
        ok6     = rd ? d6[5] : d6[6];

        if ($countones(rx_code_group[9:4]) > 3)      rd_mid = 1'b1;
        else if ($countones(rx_code_group[9:4]) < 3) rd_mid = 1'b0;
        else if (rx_code_group[9:4] == 6'b111000)    rd_mid = 1'b1;
        else if (rx_code_group[9:4] == 6'b000111)    rd_mid = 1'b0;
        else                                         rd_mid = rd;

        if ($countones(rx_code_group[3:0]) > 2)      rd_nxt = 1'b1;
        else if ($countones(rx_code_group[3:0]) < 2) rd_nxt = 1'b0;
        else if (rx_code_group[3:0] == 4'b1100)      rd_nxt = 1'b1;
        else if (rx_code_group[3:0] == 4'b0011)      rd_nxt = 1'b0;
        else                                         rd_nxt = rd_mid;

        d4      = dec4(rx_code_group[3:0], rd_mid, d6[4:0]);
        d_valid = ok6 && d4[3];
        d_byte  = {d4[2:0], d6[4:0]};

        // specials only count in the form legal for the current RD
        is_comma   = (rx_code_group == (rd ? 10'h305 : 10'h0FA));
        is_start   = (rx_code_group == (rd ? 10'h097 : 10'h368));
        is_term    = (rx_code_group == (rd ? 10'h117 : 10'h2E8));
        is_carrier = (rx_code_group == (rd ? 10'h057 : 10'h3A8));
    end

    // Next state and next registered GMII outputs
    always_comb begin
        state_nxt = state;
        dv_nxt    = 1'b0;
        er_nxt    = 1'b0;
        rxd_nxt   = '0;
        if (!sync_status) begin
            state_nxt = LINK_FAILED;
        end else begin
            case (state)
                LINK_FAILED: state_nxt = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (is_comma) state_nxt = RX_K;
                end
                RX_K: state_nxt = d_valid ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (is_comma) begin
                        state_nxt = RX_K;
                    end else if (is_start) begin
                        state_nxt = RECEIVE;
                        dv_nxt    = 1'b1;
                        rxd_nxt   = 8'h55;
                    end else begin
                        state_nxt = WAIT_FOR_K;
                    end
                end
                RECEIVE: begin
                    if (d_valid) begin
                        dv_nxt  = 1'b1;
                        rxd_nxt = d_byte;
                    end else if (is_term) begin
                        state_nxt = TRI_RRI;
                    end else if (is_comma) begin
                        state_nxt = RX_K;
                        er_nxt    = 1'b1;
                    end else begin
                        dv_nxt = 1'b1;
                        er_nxt = 1'b1;
                    end
                end
                TRI_RRI: begin
                    state_nxt = WAIT_FOR_K;
                    er_nxt    = !is_carrier;
                end
                default: state_nxt = LINK_FAILED;
            endcase
        end
    end

    // State, running disparity and output registers
    always_ff @(posedge GTX_CLK or negedge RESET) begin
        if (!RESET) begin
            state <= LINK_FAILED;
            rd    <= 1'b0;
            RXD   <= '0;
            RX_DV <= 1'b0;
            RX_ER <= 1'b0;
        end else begin
            state <= state_nxt;
            rd    <= rd_nxt;
            RXD   <= rxd_nxt;
            RX_DV <= dv_nxt;
            RX_ER <= er_nxt;
        end
    end

endmodule

// File: tb/tb_rx_pcs_decode.sv
// Bench for rx_pcs_decode: code-groups are driven on the falling edge, the
// expected {RX_DV, RX_ER, RXD} is queued, and popped for comparison 1 unit
// after the rising edge that registers it.
module tb_rx_pcs_decode;

    logic       GTX_CLK = 1'b0;
    logic       RESET   = 1'b0;
    logic [9:0] rx_code_group = '0;
    logic       sync_status   = 1'b0;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;

    localparam logic [9:0] K285  = 10'h0FA;  // RD-
    localparam logic [9:0] D162  = 10'h245;  // RD+
    localparam logic [9:0] S     = 10'h368;  // RD-
    localparam logic [9:0] T     = 10'h2E8;
    localparam logic [9:0] R     = 10'h3A8;
    localparam logic [9:0] V     = 10'h1E8;
    localparam logic [9:0] D215  = 10'h2AA;  // neutral
    localparam logic [9:0] D000  = 10'h274;  // RD-, ends RD-
    localparam logic [9:0] D317  = 10'h2B1;  // RD-, ends RD-
    localparam logic [9:0] D177  = 10'h237;  // RD- A7, ends RD+
    localparam logic [9:0] D210P = 10'h2A4;  // RD+, ends RD-
    localparam logic [9:0] D000P = 10'h18B;  // RD+ form, ends RD+
    localparam logic [9:0] ILL   = 10'h000;

    // expected {dv, er, rxd}
    localparam logic [9:0] E0   = 10'h000;
    localparam logic [9:0] EPRE = 10'h255;
    localparam logic [9:0] EB5  = 10'h2B5;
    localparam logic [9:0] EERR = 10'h300;
    localparam logic [9:0] EEND = 10'h100;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [9:0]  sb[$];

    rx_pcs_decode dut (
        .GTX_CLK      (GTX_CLK),
        .RESET        (RESET),
        .rx_code_group(rx_code_group),
        .sync_status  (sync_status),
        .RXD          (RXD),
        .RX_DV        (RX_DV),
        .RX_ER        (RX_ER)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    task automatic send(input logic [9:0] cg, input logic sync, input logic [9:0] exp);
        @(negedge GTX_CLK);
        rx_code_group = cg;
        sync_status   = sync;
        sb.push_back(exp);
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic test_reset;
        logic [9:0] got;
        sync_status   = 1'b1;
        rx_code_group = K285;
        repeat (3) @(posedge GTX_CLK);
        #1;
        got = {RX_DV, RX_ER, RXD};
        checks++;
        if (got !== E0) begin
            errors++;
            $display("FAIL reset_state: got %03h, expected %03h", got, E0);
        end
        @(negedge GTX_CLK);
        RESET = 1'b1;
    endtask

    task automatic test_idle;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic [9:0] got, want;
        cgv = '{K285, K285, D162, K285, D162, K285, D162};
        exv = '{E0, E0, E0, E0, E0, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL idle[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_packet;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic [9:0] got, want;
        cgv = '{S, D215, D215, D215, T, R, K285, D162,
                S, D000, D317, D177, D215, D210P, T, R, K285, D162};
        exv = '{EPRE, EB5, EB5, EB5, E0, E0, E0, E0,
                EPRE, 10'h200, 10'h2FF, 10'h2F1, EB5, 10'h215, E0, E0, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL packet[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_errors;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic [9:0] got, want;
        // D000P is an RD+ form received in RD-; RD then follows its bits to RD+
        cgv = '{S, D215, V, D215, ILL, D215, S, D215, D000P, D215, D210P, T, R, K285, D162};
        exv = '{EPRE, EB5, EERR, EB5, EERR, EB5, EERR, EB5, EERR, EB5, 10'h215, E0, E0, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL errors[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_early_end;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic [9:0] got, want;
        cgv = '{S, D215, K285, D162, S, D215, T, R, K285, D162};
        exv = '{EPRE, EB5, EEND, E0, EPRE, EB5, E0, E0, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL early_end[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_tri_rri_error;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic [9:0] got, want;
        cgv = '{S, D215, T, D215, D162, S, K285, D162, S, D215, T, R, K285, D162};
        exv = '{EPRE, EB5, E0, EEND, E0, E0, E0, E0, EPRE, EB5, E0, E0, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL tri_rri[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_sync_loss;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic       syv[$];
        logic [9:0] got, want;
        cgv = '{S, D215, D215, D215, D215, S, K285, D162, S, D215, T, R, K285, D162};
        syv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exv = '{EPRE, EB5, E0, E0, E0, E0, E0, E0, EPRE, EB5, E0, E0, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], syv[i], exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sync_loss[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [9:0] cgv[$];
        logic [9:0] exv[$];
        logic [9:0] got, want;
        cgv = '{S, D215};
        exv = '{EPRE, EB5};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_reset_pre[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
        // assert reset between edges; outputs must clear before the next rising edge
        @(negedge GTX_CLK);
        rx_code_group = D215;
        #2;
        RESET = 1'b0;
        #1;
        got = {RX_DV, RX_ER, RXD};
        checks++;
        if (got !== E0) begin
            errors++;
            $display("FAIL mid_reset_async: got %03h, expected %03h", got, E0);
        end
        @(posedge GTX_CLK);
        #1;
        got = {RX_DV, RX_ER, RXD};
        checks++;
        if (got !== E0) begin
            errors++;
            $display("FAIL mid_reset_held: got %03h, expected %03h", got, E0);
        end
        @(negedge GTX_CLK);
        RESET = 1'b1;
        cgv = '{D215, D215, S, D215, K285, D162, S, D215, T, R};
        exv = '{E0, E0, E0, E0, E0, E0, EPRE, EB5, E0, E0};
        for (int i = 0; i < cgv.size(); i++) begin
            send(cgv[i], 1'b1, exv[i]);
            got  = {RX_DV, RX_ER, RXD};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_reset_post[%0d]: got dv=%b er=%b rxd=%02h, expected dv=%b er=%b rxd=%02h",
                         i, got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_packet();
        test_errors();
        test_early_end();
        test_tri_rri_error();
        test_sync_loss();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
